// File: rtl/kernel_window_pkg.sv
// Shared defaults, derived coordinate widths and FSM encoding for the
// kernel window block and its coordinate counter.
package kernel_window_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_KERNEL_WIDTH = 3;
  localparam int DEF_IMG_WIDTH    = 854;
  localparam int DEF_IMG_HEIGHT   = 480;
  localparam int DEF_COL_W        = $clog2(DEF_IMG_WIDTH);
  localparam int DEF_ROW_W        = $clog2(DEF_IMG_HEIGHT);

  typedef enum logic {
    PRIME  = 1'b0,
    STREAM = 1'b1
  } kw_state_e;

endpackage

// File: rtl/kernel_window_pixel_coord_counter.sv
// Column/row position of the incoming column stream; flags line wraps and
// pulses frame_done the cycle after the last column of the frame.
module pixel_coord_counter
  import kernel_window_pkg::*;
#(
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int COL_W        = DEF_COL_W,
  parameter int ROW_W        = DEF_ROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [COL_W-1:0] col_cnt,
  output logic [ROW_W-1:0] row_cnt,
  output logic             line_wrap,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  // The line buffer only emits once full, so every frame starts at row K-1.
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_WIDTH - 1);

  logic [COL_W-1:0] col_cnt_r;
  logic [ROW_W-1:0] row_cnt_r;
  logic             frame_done_r;
  logic             line_wrap_s;
  logic             frame_end_s;

  // Decode wrap and end-of-frame for the column being accepted now.
  always_comb begin
    line_wrap_s = 1'b0;
    frame_end_s = 1'b0;
    if (advance && (col_cnt_r == COL_LAST)) begin
      line_wrap_s = 1'b1;
      frame_end_s = (row_cnt_r == ROW_LAST);
    end else begin
      line_wrap_s = 1'b0;
      frame_end_s = 1'b0;
    end
  end

  // Column/row mod counters advanced by the accept strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_r <= '0;
      row_cnt_r <= ROW_FIRST;
    end else if (advance) begin
      if (line_wrap_s) begin
        col_cnt_r <= '0;
        row_cnt_r <= frame_end_s ? ROW_FIRST : (row_cnt_r + ROW_W'(1'b1));
      end else begin
        col_cnt_r <= col_cnt_r + COL_W'(1'b1);
      end
    end
  end

  // Single-cycle end-of-frame pulse, independent of downstream readiness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
    end
  end

  assign col_cnt    = col_cnt_r;
  assign row_cnt    = row_cnt_r;
  assign line_wrap  = line_wrap_s;
  assign frame_done = frame_done_r;

endmodule

// File: rtl/kernel_window.sv
// K x K sliding window fed one pixel column per handshake; emits only
// windows lying entirely within one image line band, tagged with coordinates.
module kernel_window
  import kernel_window_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int COL_W        = $clog2(IMG_WIDTH),
  parameter int ROW_W        = $clog2(IMG_HEIGHT)
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [KERNEL_WIDTH*DATA_WIDTH-1:0]          col_data,
  input  logic                                        col_valid,
  output logic                                        col_ready,
  output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0] win_data,
  output logic                                        win_valid,
  input  logic                                        win_ready,
  output logic [COL_W-1:0]                            win_col,
  output logic [ROW_W-1:0]                            win_row,
  output logic                                        frame_done
);

  localparam int K        = KERNEL_WIDTH;
  localparam int ROW_BITS = K * DATA_WIDTH;

  // Row r of the window occupies bits [r*ROW_BITS +: ROW_BITS]; column 0 is lowest.
  logic [K-1:0][ROW_BITS-1:0] win_r;
  logic                       win_valid_r;
  logic [COL_W-1:0]           win_col_r;
  logic [ROW_W-1:0]           win_row_r;
  kw_state_e                  state_r;

  logic                       col_ready_s;
  logic                       accept_s;
  logic                       prime_done_s;
  logic [COL_W-1:0]           col_cnt_s;
  logic [ROW_W-1:0]           row_cnt_s;
  logic                       line_wrap_s;
  logic                       frame_done_s;

  pixel_coord_counter #(
    .KERNEL_WIDTH (KERNEL_WIDTH),
    .IMG_WIDTH    (IMG_WIDTH),
    .IMG_HEIGHT   (IMG_HEIGHT),
    .COL_W        (COL_W),
    .ROW_W        (ROW_W)
  ) u_coord (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (accept_s),
    .col_cnt    (col_cnt_s),
    .row_cnt    (row_cnt_s),
    .line_wrap  (line_wrap_s),
    .frame_done (frame_done_s)
  );

  // Single-register pipeline handshake and accept decode.
  always_comb begin
    col_ready_s  = !win_valid_r || win_ready;
    accept_s     = col_valid && col_ready_s;
    prime_done_s = (col_cnt_s == COL_W'(K - 2));
  end

  // Line FSM with registered valid and coordinate outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= PRIME;
      win_valid_r <= 1'b0;
      win_col_r   <= '0;
      win_row_r   <= ROW_W'(K - 1);
    end else if (accept_s) begin
      win_col_r <= col_cnt_s;
      win_row_r <= row_cnt_s;
      case (state_r)
        PRIME: begin
          // An accept here implies the previous window was taken or absent.
          win_valid_r <= 1'b0;
          if (prime_done_s) begin
            state_r <= STREAM;
          end
        end
        STREAM: begin
          win_valid_r <= 1'b1;
          if (line_wrap_s) begin
            state_r <= PRIME;
          end
        end
        default: begin
          win_valid_r <= 1'b0;
          state_r     <= PRIME;
        end
      endcase
    end else if (win_ready) begin
      win_valid_r <= 1'b0;
    end
  end

  // Window shift register: every row moves left, new column enters at K-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r <= '0;
    end else if (accept_s) begin
      for (int r = 0; r < K; r++) begin
        win_r[r] <= {col_data[r*DATA_WIDTH +: DATA_WIDTH], win_r[r][ROW_BITS-1:DATA_WIDTH]};
      end
    end
  end

  assign col_ready  = col_ready_s;
  assign win_data   = win_r;
  assign win_valid  = win_valid_r;
  assign win_col    = win_col_r;
  assign win_row    = win_row_r;
  assign frame_done = frame_done_s;

endmodule

// File: tb/tb_kernel_window.sv
// Directed + randomized bench for kernel_window (K=3, 8x6 image) against a
// coordinate-based reference model of the expected windows.
module tb_kernel_window;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clk;
  logic          rst_n;
  logic [23:0]   col_data;
  logic          col_valid;
  logic          col_ready;
  logic [71:0]   win_data;
  logic          win_valid;
  logic          win_ready;
  logic [2:0]    win_col;
  logic [2:0]    win_row;
  logic          frame_done;

  kernel_window #(
    .DATA_WIDTH   (DW),
    .KERNEL_WIDTH (K),
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .COL_W        (3),
    .ROW_W        (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_data   (col_data),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_col    (win_col),
    .win_row    (win_row),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stream position of the next column to send, and the expected output state.
  int          p_col, p_row;
  bit          m_valid, m_fd;
  logic [71:0] m_win;
  int          m_col, m_row;
  int          n_win, n_hand, n_fd, n_acc;

  function automatic logic [23:0] coldat(input int col, input int row);
    logic [23:0] d;
    for (int r = 0; r < K; r++) d[r*8 +: 8] = 8'((row - (K - 1) + r) * 16 + col);
    return d;
  endfunction

  // Window whose rightmost column is (col,row): pixel (r,c) is image (row-2+r, col-2+c).
  function automatic logic [71:0] exp_win(input int col, input int row);
    logic [71:0] w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K + c)*8 +: 8] = 8'((row - (K - 1) + r) * 16 + (col - (K - 1) + c));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p_col = 0; p_row = K - 1;
    m_valid = 1'b0; m_fd = 1'b0;
    m_win = '0; m_col = 0; m_row = K - 1;
  endtask

  // One clock: drive at negedge, predict at posedge, check at next negedge.
  task automatic step(input bit v, input bit rdy);
    bit acc;
    col_valid = v;
    win_ready = rdy;
    col_data  = v ? coldat(p_col, p_row) : 24'($urandom);
    #1;
    chk("col_ready", 72'(col_ready), 72'(!m_valid || rdy));
    if (win_valid && win_ready) n_hand++;
    acc = v && (!m_valid || rdy);
    @(posedge clk);
    m_fd = acc && (p_col == W - 1) && (p_row == H - 1);
    if (acc && p_col >= K - 1) begin
      m_valid = 1'b1;
      m_win   = exp_win(p_col, p_row);
      m_col   = p_col;
      m_row   = p_row;
      n_win++;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (acc) begin
      n_acc++;
      p_col++;
      if (p_col == W) begin
        p_col = 0;
        p_row = (p_row == H - 1) ? K - 1 : p_row + 1;
      end
    end
    @(negedge clk);
    chk("win_valid", 72'(win_valid), 72'(m_valid));
    chk("frame_done", 72'(frame_done), 72'(m_fd));
    if (frame_done) n_fd++;
    if (m_valid) begin
      chk("win_data", win_data, m_win);
      chk("win_col", 72'(win_col), 72'(m_col));
      chk("win_row", 72'(win_row), 72'(m_row));
    end
  endtask

  initial begin
    int w0, h0, f0, a0, guard, bp_col;
    logic [71:0] held;
    n_win = 0; n_hand = 0; n_fd = 0; n_acc = 0;
    rst_n = 1'b0; col_valid = 1'b0; win_ready = 1'b0; col_data = '0;
    model_reset();

    // Power-on reset values.
    @(negedge clk);
    chk("rst_valid", 72'(win_valid), 72'(0));
    chk("rst_fd", 72'(frame_done), 72'(0));
    chk("rst_data", win_data, 72'(0));
    chk("rst_col", 72'(win_col), 72'(0));
    chk("rst_row", 72'(win_row), 72'(K - 1));
    @(negedge clk);
    rst_n = 1'b1;

    // Prime and stream the first line at full rate.
    w0 = n_win;
    for (int c = 0; c < W; c++) begin
      step(1'b1, 1'b1);
      if (c == K - 1) begin
        chk("first_col", 72'(win_col), 72'(2));
        chk("first_row", 72'(win_row), 72'(2));
        chk("first_px00", 72'(win_data[7:0]), 72'(8'h00));
        chk("first_px22", 72'(win_data[(2*K+2)*8 +: 8]), 72'(8'h22));
      end
    end
    chk("line_windows", 72'(n_win - w0), 72'(W - K + 1));

    // Line wrap into row 3: first window must be col 2, row 3, row-3 pixels only.
    for (int c = 0; c < K; c++) step(1'b1, 1'b1);
    chk("wrap_col", 72'(win_col), 72'(2));
    chk("wrap_row", 72'(win_row), 72'(3));
    step(1'b1, 1'b1);

    // Backpressure: 5 stalled cycles with col_valid held high.
    bp_col = m_col;
    held   = win_data;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      chk("bp_hold", win_data, held);
    end
    step(1'b1, 1'b1);
    chk("bp_next_col", 72'(win_col), 72'(bp_col + 1));
    while (p_col != 0) step(1'b1, 1'b1);

    // Reset asserted mid-line while a window is stalled.
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    rst_n = 1'b0; win_ready = 1'b0; col_valid = 1'b1;
    #1;
    chk("mid_rst_valid", 72'(win_valid), 72'(0));
    chk("mid_rst_fd", 72'(frame_done), 72'(0));
    chk("mid_rst_ready", 72'(col_ready), 72'(1));
    chk("mid_rst_col", 72'(win_col), 72'(0));
    chk("mid_rst_row", 72'(win_row), 72'(K - 1));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; col_valid = 1'b0;
    model_reset();

    // Full frame with random col_valid gaps.
    h0 = n_hand; f0 = n_fd; a0 = n_acc; guard = 0;
    while ((n_acc - a0) < (H - K + 1) * W && guard < 1000) begin
      step($urandom_range(0, 3) != 0, 1'b1);
      guard++;
    end
    chk("frame1_accepts", 72'(n_acc - a0), 72'((H - K + 1) * W));
    step(1'b0, 1'b1);
    chk("frame1_windows", 72'(n_hand - h0), 72'((W - K + 1) * (H - K + 1)));
    chk("frame1_fd_count", 72'(n_fd - f0), 72'(1));

    // Frame with random gaps and random downstream backpressure.
    h0 = n_hand; f0 = n_fd; a0 = n_acc; guard = 0;
    while ((n_acc - a0) < (H - K + 1) * W && guard < 2000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      guard++;
    end
    chk("frame2_accepts", 72'(n_acc - a0), 72'((H - K + 1) * W));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("frame2_windows", 72'(n_hand - h0), 72'((W - K + 1) * (H - K + 1)));
    chk("frame2_fd_count", 72'(n_fd - f0), 72'(1));

    // Full-rate stress over two frames.
    h0 = n_hand; f0 = n_fd;
    for (int i = 0; i < 2 * (H - K + 1) * W; i++) begin
      step(1'b1, 1'b1);
      if (i == K - 1) begin
        chk("restart_col", 72'(win_col), 72'(2));
        chk("restart_row", 72'(win_row), 72'(2));
      end
    end
    step(1'b0, 1'b1);
    chk("stress_windows", 72'(n_hand - h0), 72'(2 * (W - K + 1) * (H - K + 1)));
    chk("stress_fd_count", 72'(n_fd - f0), 72'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kernel_window.md
Name: kernel_window

Overview:
- Reader-side consumer of the line buffer chain; a chain of line-buffer FIFOs plus the live pixel feeds it.
- Accepts one vertical column of KERNEL_WIDTH pixels per handshake and shifts it into a KERNEL_WIDTH x KERNEL_WIDTH register window.
- Tracks column and row position internally. Suppresses horizontal border windows, i.e. windows that would straddle two image lines.
- Presents only legal windows, with image coordinates, to the downstream gradient/HOG stage over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- KERNEL_WIDTH, 3, window side K (>= 2).
- IMG_WIDTH, 854, pixels per line. Must equal the line buffer FIFO depth.
- IMG_HEIGHT, 480, lines per frame.
- COL_W, $clog2(IMG_WIDTH), width of the column coordinate.
- ROW_W, $clog2(IMG_HEIGHT), width of the row coordinate.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous, active-low reset.
- col_data, in, K*DATA_WIDTH: pixel column. Pixel r is col_data[r*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top/oldest line, r=K-1 is the live line.
- col_valid, in, 1: col_data is valid.
- col_ready, out, 1: block accepts a column this cycle.
- win_data, out, K*K*DATA_WIDTH: window. Pixel (r,c) is win_data[(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; c=0 is the leftmost/oldest column.
- win_valid, out, 1: win_data, win_col and win_row hold a legal window.
- win_ready, in, 1: downstream accepts the window.
- win_col, out, COL_W: image column of the rightmost window column.
- win_row, out, ROW_W: image row of the bottom window line.
- frame_done, out, 1: single-cycle pulse at end of frame.

Behaviour:
- Reset (async, rst_n=0):
  - Window registers cleared to 0.
  - win_valid=0, frame_done=0, win_col=0, win_row=K-1.
  - Internal col_cnt=0, row_cnt=K-1. FSM in PRIME.
  - Reset takes effect immediately, mid-line or mid-frame. Any partial window is discarded; the next accepted column is treated as column 0 of row K-1.
- Handshake:
  - col_ready = !win_valid || win_ready. This is the combinational single-register pipeline rule.
  - A column is accepted when col_valid && col_ready.
  - Throughput is 1 column/cycle with win_ready held high.
- Accept action:
  - Shift every window row left one column and load col_data into column K-1.
  - Register win_col=col_cnt and win_row=row_cnt.
  - Advance the counters.
- Latency: a window is valid the cycle after its rightmost column is accepted.
- Stability: while win_valid && !win_ready, win_data, win_col and win_row hold stable and no column is accepted.
- win_valid next value:
  - 1 if a column is accepted and that column's col_cnt >= K-1.
  - Else 0 if win_ready.
  - Else hold.
- FSM, per line:
  - PRIME: col_cnt < K-1. Accepted columns fill the window and produce no output.
  - STREAM: col_cnt >= K-1. Every accepted column produces a window.
  - PRIME -> STREAM on accepting column K-2.
  - STREAM -> PRIME on accepting column IMG_WIDTH-1 (line wrap).
- Counters:
  - col_cnt wraps from IMG_WIDTH-1 to 0 and row_cnt increments on the wrap.
  - On accepting column IMG_WIDTH-1 of row IMG_HEIGHT-1: row_cnt returns to K-1 and frame_done pulses high for exactly one cycle on the following cycle. This happens regardless of win_ready.
- The input stream begins at image row K-1, because the line buffer issues no data until it is full. A frame therefore carries IMG_HEIGHT-K+1 lines.
- Windows per frame = (IMG_WIDTH-K+1) * (IMG_HEIGHT-K+1).
- No window ever mixes columns from two different lines. Stale columns from the previous line are flushed by PRIME.
- col_valid is ignored while col_ready=0. Upstream must hold col_data.

Decomposition:
- Shared package kernel_window_pkg holds:
  - Default DATA_WIDTH, KERNEL_WIDTH, IMG_WIDTH and IMG_HEIGHT.
  - Derived COL_W and ROW_W.
  - FSM state encoding: PRIME=1'b0, STREAM=1'b1.
- One sub-module: pixel_coord_counter.
  - Holds the col/row mod counters, the line-wrap flag and the frame_done generation.
  - Advanced by an accept strobe; asynchronous active-low reset.
- The window shift register and output handshake stay in kernel_window.

Test Plan:
- Bench configuration for all scenarios: K=3, IMG_WIDTH=8, IMG_HEIGHT=6. Pixel value = row*16+col.
- Reset check: assert rst_n=0 mid-stream -> win_valid=0, frame_done=0 and col_ready=1 in the same cycle. After release, the first accepted column is treated as col 0, row 2.
- Prime and stream, win_ready=1: accept row-2 columns 0..7 -> no window for cols 0 and 1. First window appears one cycle after col 2, with win_col=2, win_row=2 and pixel (0,0)=0x00, (2,2)=0x22. The line produces exactly 6 windows.
- Backpressure: hold win_ready=0 for 5 cycles while col_valid=1 -> col_ready=0 and win_data stable for all 5 cycles. On release, the next window has win_col incremented by exactly 1; no column is lost or duplicated.
- Line wrap: accept col 7 of row 2, then cols 0 and 1 of row 3 -> no window contains a row-2 col-7 pixel alongside row-3 pixels. The next window has win_col=2, win_row=3.
- Frame end: stream 4 lines x 8 columns with random col_valid gaps -> 24 windows total. frame_done pulses exactly once, one cycle after the last accepted column. Counters restart at col 0, row 2 for the next frame.
- Full-rate stress: col_valid=1 and win_ready=1 continuously over 2 frames -> one window per cycle in STREAM, and 48 windows total.
